// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a small FIFO.
// Frames are sent back-to-back with no idle gap for as long as the FIFO holds words.
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | line high; pops the head word when the FIFO is non-empty
// START | start bit (line low)
// DATA  | data bits, LSB first
// PAR   | optional parity bit over the data bits
// STOP  | stop bit(s); pops the next word directly into START if one is queued
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 11
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TC        = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_cnt;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 overflow_q;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 par_bit;
    logic                 serial;

    assign ready = (fifo_cnt != FULL);
    assign push  = i_Tx_DV && ready;

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    // A full FIFO rejects the write even when a pop frees a slot in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= i_Tx_DV && !ready;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        bit_end = (cnt_q == TC);
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    data_d  = mem[rd_ptr];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        done_d = 1'b1;
                        // Chain straight into the next start bit when data is waiting.
                        if (fifo_cnt != '0) begin
                            pop     = 1'b1;
                            data_d  = mem[rd_ptr];
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign par_bit = (PARITY == 1) ? ~^data_q : ^data_q;

    always_comb begin
        serial = 1'b1;
        case (state_q)
            S_START: serial = 1'b0;
            S_DATA:  serial = data_q[idx_q];
            S_PAR:   serial = par_bit;
            default: serial = 1'b1;
        endcase
    end

    assign o_Tx_Serial   = serial;
    assign o_Tx_Active   = (state_q == S_START) || (state_q == S_DATA) ||
                           (state_q == S_PAR)   || (state_q == S_STOP);
    assign o_Tx_Done     = done_q;
    assign o_Tx_Overflow = overflow_q;
    assign o_Tx_Ready    = ready;
    assign o_Fifo_Count  = fifo_cnt;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8N1, 7O2, 8E1) at 4 clocks per bit,
// checked against hand-computed frame bit patterns and FIFO timing.
module tb_uart_tx_cfg;

    localparam int CPB  = 4;
    localparam int MAXS = 256;

    logic clk = 1'b0;
    logic rst;
    logic dv_a, dv_b, dv_c;
    logic [7:0] byte_a, byte_c;
    logic [6:0] byte_b;
    logic rdy_a, ovf_a, act_a, ser_a, done_a;
    logic rdy_b, ovf_b, act_b, ser_b, done_b;
    logic rdy_c, ovf_c, act_c, ser_c, done_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Ready(rdy_a), .o_Tx_Overflow(ovf_a), .o_Fifo_Count(cnt_a),
        .o_Tx_Active(act_a), .o_Tx_Serial(ser_a), .o_Tx_Done(done_a));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Ready(rdy_b), .o_Tx_Overflow(ovf_b), .o_Fifo_Count(cnt_b),
        .o_Tx_Active(act_b), .o_Tx_Serial(ser_b), .o_Tx_Done(done_b));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_c), .i_Tx_Byte(byte_c),
        .o_Tx_Ready(rdy_c), .o_Tx_Overflow(ovf_c), .o_Fifo_Count(cnt_c),
        .o_Tx_Active(act_c), .o_Tx_Serial(ser_c), .o_Tx_Done(done_c));

    int   sel;
    logic s_line, s_act, s_done, s_ovf, s_rdy;
    logic [2:0] s_cnt;

    always_comb begin
        s_line = ser_a; s_act = act_a; s_done = done_a; s_ovf = ovf_a; s_rdy = rdy_a; s_cnt = cnt_a;
        case (sel)
            1: begin s_line = ser_b; s_act = act_b; s_done = done_b; s_ovf = ovf_b; s_rdy = rdy_b; s_cnt = cnt_b; end
            2: begin s_line = ser_c; s_act = act_c; s_done = done_c; s_ovf = ovf_c; s_rdy = rdy_c; s_cnt = cnt_c; end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        logic [8:0]  data;
        int          nbits;
        logic [11:0] bits;   // first bit on the line is bits[nbits-1]
    } vec_t;

    vec_t vecs[6];

    int   tests  = 0;
    int   failed = 0;
    logic cap_line [MAXS];
    logic cap_act  [MAXS];
    logic cap_done [MAXS];
    logic cap_ovf  [MAXS];
    logic cap_rdy  [MAXS];
    int   cap_cnt  [MAXS];
    int   wr_at   [8];
    logic [8:0] wr_word [8];
    int   n_wr;
    int   rst_at;
    logic exp_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input int j);
        dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
        rst  = (j == rst_at);
        for (int k = 0; k < n_wr; k++) begin
            if (wr_at[k] == j) begin
                case (sel)
                    1:       begin dv_b = 1'b1; byte_b = wr_word[k][6:0]; end
                    2:       begin dv_c = 1'b1; byte_c = wr_word[k][7:0]; end
                    default: begin dv_a = 1'b1; byte_a = wr_word[k][7:0]; end
                endcase
            end
        end
    endtask

    // Sample index j is the clock period j cycles after the first write cycle.
    task automatic run(input int s, input int n);
        sel = s;
        @(negedge clk);
        apply(0);
        for (int j = 1; j < n; j++) begin
            @(negedge clk);
            cap_line[j] = s_line; cap_act[j] = s_act; cap_done[j] = s_done;
            cap_ovf[j]  = s_ovf;  cap_rdy[j] = s_rdy; cap_cnt[j]  = int'(s_cnt);
            apply(j);
        end
        @(negedge clk);
        dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0; rst = 1'b0;
    endtask

    task automatic push_bits(input logic [11:0] b, input int nb);
        for (int k = 0; k < nb; k++) exp_q.push_back(b[nb-1-k]);
    endtask

    task automatic push_frame_8n1(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(d[k]);
        exp_q.push_back(1'b1);
    endtask

    // Expected frames start at j = 2 and run back-to-back; line idles high otherwise.
    task automatic check_run(input string nm, input int fbits, input int n);
        int fl, span, nfr, bad_line, bad_act, bad_done;
        logic in_f, e_line, e_done;
        fl = fbits * CPB;
        span = exp_q.size() * CPB;
        nfr = exp_q.size() / fbits;
        bad_line = 0; bad_act = 0; bad_done = 0;
        for (int j = 1; j < n; j++) begin
            in_f   = (j >= 2) && (j < 2 + span);
            e_line = in_f ? exp_q[(j - 2) / CPB] : 1'b1;
            e_done = (j >= 2 + fl) && (((j - 2) % fl) == 0) && (((j - 2) / fl) <= nfr);
            if (cap_line[j] !== e_line) bad_line++;
            if (cap_act[j]  !== in_f)   bad_act++;
            if (cap_done[j] !== e_done) bad_done++;
        end
        chk($sformatf("%s line_errors", nm), bad_line, 0);
        chk($sformatf("%s active_errors", nm), bad_act, 0);
        chk($sformatf("%s done_errors", nm), bad_done, 0);
    endtask

    initial begin
        int n, peak, novf, ndone, bad;
        vecs[0] = '{0, 9'h0A5, 10, 12'b000101001011};
        vecs[1] = '{0, 9'h03C, 10, 12'b000001111001};
        vecs[2] = '{1, 9'h035, 11, 12'b001010110111};
        vecs[3] = '{1, 9'h000, 11, 12'b000000000111};
        vecs[4] = '{2, 9'h05A, 11, 12'b000101101001};
        vecs[5] = '{2, 9'h001, 11, 12'b001000000011};

        rst = 1'b1; dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
        byte_a = '0; byte_b = '0; byte_c = '0;
        sel = 0; n_wr = 0; rst_at = -1;
        repeat (3) @(negedge clk);
        chk("reset serial_a", int'(ser_a), 1);
        chk("reset active_a", int'(act_a), 0);
        chk("reset count_a", int'(cnt_a), 0);
        chk("reset ready_a", int'(rdy_a), 1);
        chk("reset done_a", int'(done_a), 0);
        chk("reset overflow_a", int'(ovf_a), 0);
        chk("reset serial_b", int'(ser_b), 1);
        chk("reset serial_c", int'(ser_c), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            exp_q.delete();
            push_bits(vecs[v].bits, vecs[v].nbits);
            n_wr = 1; wr_at[0] = 0; wr_word[0] = vecs[v].data; rst_at = -1;
            n = vecs[v].nbits * CPB + 8;
            run(vecs[v].sel, n);
            check_run($sformatf("vec%0d", v), vecs[v].nbits, n);
            chk($sformatf("vec%0d final_count", v), cap_cnt[n-1], 0);
            repeat (2) @(negedge clk);
        end

        // 8E1 back-to-back: 0xFF (parity 0) then 0x01 (parity 1) with no idle clock.
        exp_q.delete();
        push_bits(12'b001111111101, 11);
        push_bits(12'b001000000011, 11);
        n_wr = 2; wr_at[0] = 0; wr_word[0] = 9'h0FF; wr_at[1] = 1; wr_word[1] = 9'h001; rst_at = -1;
        n = 2 * 11 * CPB + 8;
        run(2, n);
        check_run("b2b", 11, n);
        chk("b2b active_at_seam", int'(cap_act[45] && cap_act[46]), 1);
        chk("b2b second_start", int'(cap_line[46]), 0);
        chk("b2b parity_first", int'(cap_line[2 + 9 * CPB]), 0);
        repeat (2) @(negedge clk);

        // Six writes on consecutive cycles into a depth-4 FIFO: sixth is dropped.
        exp_q.delete();
        n_wr = 6;
        for (int k = 0; k < 6; k++) begin
            wr_at[k] = k; wr_word[k] = 9'(8'h11 * (k + 1));
        end
        for (int k = 0; k < 5; k++) push_frame_8n1(8'(8'h11 * (k + 1)));
        rst_at = -1;
        n = 5 * 10 * CPB + 6;
        run(0, n);
        check_run("burst", 10, n);
        peak = 0; novf = 0;
        for (int j = 1; j < n; j++) begin
            if (cap_cnt[j] > peak) peak = cap_cnt[j];
            if (cap_ovf[j]) novf++;
        end
        chk("burst peak_count", peak, 4);
        chk("burst overflow_pulses", novf, 1);
        chk("burst overflow_cycle6", int'(cap_ovf[6]), 1);
        chk("burst ready_when_full", int'(cap_rdy[5]), 0);
        repeat (2) @(negedge clk);

        // Reset for one clock during DATA bit 3 with two words still queued.
        exp_q.delete();
        n_wr = 3;
        wr_at[0] = 0; wr_word[0] = 9'h0A5;
        wr_at[1] = 1; wr_word[1] = 9'h03C;
        wr_at[2] = 2; wr_word[2] = 9'h011;
        rst_at = 19;
        n = 80;
        run(0, n);
        chk("rst count_before", cap_cnt[19], 2);
        chk("rst bit3_line", int'(cap_line[18]), 0);
        chk("rst active_before", int'(cap_act[19]), 1);
        chk("rst serial_after", int'(cap_line[20]), 1);
        chk("rst count_after", cap_cnt[20], 0);
        chk("rst ready_after", int'(cap_rdy[20]), 1);
        bad = 0; ndone = 0;
        for (int j = 1; j < n; j++) begin
            if (cap_done[j]) ndone++;
            if (j >= 20 && (cap_line[j] !== 1'b1 || cap_act[j] !== 1'b0)) bad++;
        end
        chk("rst idle_errors", bad, 0);
        chk("rst done_pulses", ndone, 0);
        rst_at = -1;
        repeat (2) @(negedge clk);

        // Write collides with the pop at the end of frame 1 while the FIFO is full.
        exp_q.delete();
        n_wr = 6;
        for (int k = 0; k < 5; k++) begin
            wr_at[k] = k; wr_word[k] = 9'(8'h21 * (k + 1));
            push_frame_8n1(8'(8'h21 * (k + 1)));
        end
        wr_at[5] = 41; wr_word[5] = 9'h0EE;
        n = 5 * 10 * CPB + 6;
        run(0, n);
        check_run("fullpop", 10, n);
        novf = 0;
        for (int j = 1; j < n; j++) if (cap_ovf[j]) novf++;
        chk("fullpop count_before", cap_cnt[41], 4);
        chk("fullpop count_after", cap_cnt[42], 3);
        chk("fullpop overflow_cycle", int'(cap_ovf[42]), 1);
        chk("fullpop overflow_pulses", novf, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
